// File: rtl/store_buffer.sv
// Posted-write store buffer between the CPU datapath and data memory.
// Stores are queued and drained one per cycle; loads forward from the youngest matching entry.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          st_valid,
  input  logic [AW-1:0] st_addr,
  input  logic [31:0]   st_data,
  output logic          st_ready,
  input  logic          ld_valid,
  input  logic [AW-1:0] ld_addr,
  output logic [31:0]   ld_data,
  output logic          sb_empty,
  output logic          dm_we,
  output logic [AW-1:0] dm_addr,
  output logic [31:0]   dm_din,
  input  logic [31:0]   dm_dout
);

  localparam int PW = $clog2(DEPTH);

  logic [AW-1:2] r_addr [DEPTH];
  logic [31:0]   r_data [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [PW:0]   r_count;

  logic          w_push;
  logic          w_drain;
  logic          w_need_dm;
  logic          w_hit;
  logic [31:0]   w_fwd;
  logic [PW-1:0] w_idx;
  logic          w_unused;

  // Word-aligned buffer: the byte offset of a store address carries no information.
  assign w_unused = ^st_addr[1:0];

  assign st_ready = (r_count != (PW+1)'(DEPTH));
  assign sb_empty = (r_count == '0);
  assign w_push   = st_valid & st_ready;

  // Walk entries oldest to youngest so the last match found is the youngest one.
  // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
  always_comb begin
    w_hit = 1'b0;
    w_fwd = '0;
    w_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_head + PW'(i);
      if (((PW+1)'(i) < r_count) && (r_addr[w_idx] == ld_addr[AW-1:2])) begin
        w_hit = ld_valid;
        w_fwd = r_data[w_idx];
      end
    end
  end

  assign w_need_dm = ld_valid & ~w_hit;
  assign w_drain   = (r_count != '0) & ~w_need_dm;

  // A drain in a reset cycle must not reach dm, since the entry is being discarded.
  assign dm_we   = w_drain & ~reset;
  assign dm_addr = w_need_dm ? ld_addr : {r_addr[r_head], 2'b00};
  assign dm_din  = r_data[r_head];
  assign ld_data = w_hit ? w_fwd : dm_dout;

  // NOTE: entry storage is not reset; validity is tracked by head/count alone.
  always_ff @(posedge clk) begin
    if (w_push && !reset) begin
      r_addr[r_tail] <= st_addr[AW-1:2];
      r_data[r_tail] <= st_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push)  r_tail <= r_tail + 1'b1;
      if (w_drain) r_head <= r_head + 1'b1;
      case ({w_push, w_drain})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer with a simple word-addressed dm model.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_ready;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic        sb_empty;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_din;
  logic [31:0] dm_dout;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem [0:255];
  logic [31:0] log_a [$];
  logic [31:0] log_d [$];

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(4), .AW(32)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
    .sb_empty(sb_empty),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_din(dm_din), .dm_dout(dm_dout)
  );

  assign dm_dout = mem[dm_addr[9:2]];

  always @(posedge clk) begin
    if (dm_we) begin
      mem[dm_addr[9:2]] <= dm_din;
      log_a.push_back(dm_addr);
      log_d.push_back(dm_din);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
  endtask

  task automatic clear_log();
    log_a.delete();
    log_d.delete();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h10] = 32'h0000_1234;  // byte address 0x40
    reset = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0;
    ld_valid = 1'b0; ld_addr = '0;
    tick(); tick();
    reset = 1'b0;
    #1;
    check("reset_st_ready", {31'd0, st_ready}, 32'd1);
    check("reset_sb_empty", {31'd0, sb_empty}, 32'd1);
    check("reset_dm_we",    {31'd0, dm_we},    32'd0);

    // Single store drains on the next edge.
    clear_log();
    push(32'h10, 32'hAAAA_0001);
    tick();
    st_valid = 1'b0;
    check("t1_dm_we",    {31'd0, dm_we}, 32'd1);
    check("t1_dm_addr",  dm_addr, 32'h10);
    check("t1_dm_din",   dm_din,  32'hAAAA_0001);
    check("t1_nonempty", {31'd0, sb_empty}, 32'd0);
    tick();
    check("t1_empty",    {31'd0, sb_empty}, 32'd1);
    check("t1_idle_we",  {31'd0, dm_we}, 32'd0);
    check("t1_mem",      mem[8'h04], 32'hAAAA_0001);

    // Same-address stores under a held hitting load.
    clear_log();
    ld_valid = 1'b1; ld_addr = 32'h20;
    push(32'h20, 32'd1);
    #1;
    check("t2_pre_miss", ld_data, 32'd0);
    check("t2_pre_addr", dm_addr, 32'h20);
    tick();
    push(32'h20, 32'd2);
    #1;
    check("t2_fwd1",     ld_data, 32'd1);
    check("t2_drain1",   {31'd0, dm_we}, 32'd1);
    tick();
    st_valid = 1'b0;
    check("t2_fwd2",     ld_data, 32'd2);
    check("t2_din2",     dm_din, 32'd2);
    tick();
    check("t2_no_stale", ld_data, 32'd2);
    check("t2_idle_we",  {31'd0, dm_we}, 32'd0);
    check("t2_nwrites",  log_d.size(), 32'd2);
    if (log_d.size() == 2) begin
      check("t2_order0", log_d[0], 32'd1);
      check("t2_order1", log_d[1], 32'd2);
    end
    ld_valid = 1'b0;

    // Fill under a miss-holding load; the fifth store is refused.
    clear_log();
    ld_valid = 1'b1; ld_addr = 32'h80;
    push(32'h30, 32'h31); #1; check("t3_rdy0", {31'd0, st_ready}, 32'd1); tick();
    push(32'h34, 32'h32); #1; check("t3_rdy1", {31'd0, st_ready}, 32'd1); tick();
    push(32'h30, 32'h33); #1; check("t3_rdy2", {31'd0, st_ready}, 32'd1); tick();
    push(32'h38, 32'h34); #1; check("t3_rdy3", {31'd0, st_ready}, 32'd1); tick();
    push(32'h3C, 32'h35);
    #1;
    check("t3_full",     {31'd0, st_ready}, 32'd0);
    check("t3_stall_we", {31'd0, dm_we}, 32'd0);
    check("t3_ld_addr",  dm_addr, 32'h80);
    tick();
    st_valid = 1'b0;
    check("t3_still_full", {31'd0, st_ready}, 32'd0);
    ld_addr = 32'h30; #1;
    check("t3_youngest",   ld_data, 32'h33);
    ld_addr = 32'h31; #1;
    check("t3_byte_off",   ld_data, 32'h33);
    ld_addr = 32'h3C; #1;
    check("t3_dropped",    ld_data, 32'h0);
    check("t3_drop_addr",  dm_addr, 32'h3C);
    ld_addr = 32'h80; #1;
    check("t3_no_writes",  log_d.size(), 32'd0);

    // Drain from full; push only lands once a slot is free.
    ld_valid = 1'b0;
    push(32'h44, 32'h44);
    #1;
    check("t4_full_rdy",   {31'd0, st_ready}, 32'd0);
    check("t4_oldest_adr", dm_addr, 32'h30);
    check("t4_oldest_din", dm_din, 32'h31);
    tick();
    check("t4_freed_rdy",  {31'd0, st_ready}, 32'd1);
    check("t4_next_din",   dm_din, 32'h32);
    tick();
    st_valid = 1'b0;
    check("t4_rdy_keep",   {31'd0, st_ready}, 32'd1);
    tick(); tick(); tick();
    check("t4_empty",      {31'd0, sb_empty}, 32'd1);
    check("t4_nwrites",    log_d.size(), 32'd5);
    if (log_d.size() == 5) begin
      check("t4_w0a", log_a[0], 32'h30); check("t4_w0d", log_d[0], 32'h31);
      check("t4_w1a", log_a[1], 32'h34); check("t4_w1d", log_d[1], 32'h32);
      check("t4_w2a", log_a[2], 32'h30); check("t4_w2d", log_d[2], 32'h33);
      check("t4_w3a", log_a[3], 32'h38); check("t4_w3d", log_d[3], 32'h34);
      check("t4_w4a", log_a[4], 32'h44); check("t4_w4d", log_d[4], 32'h44);
    end
    check("t4_mem30", mem[8'h0C], 32'h33);

    // Load miss to dm stalls draining until ld_valid falls.
    clear_log();
    ld_valid = 1'b1; ld_addr = 32'h40;
    push(32'h50, 32'h51); tick();
    push(32'h54, 32'h52); tick();
    st_valid = 1'b0;
    check("t5_ld_data", ld_data, 32'h1234);
    check("t5_dm_addr", dm_addr, 32'h40);
    check("t5_dm_we",   {31'd0, dm_we}, 32'd0);
    tick();
    check("t5_stall",   {31'd0, dm_we}, 32'd0);
    ld_valid = 1'b0;
    #1;
    check("t5_resume_we",   {31'd0, dm_we}, 32'd1);
    check("t5_resume_addr", dm_addr, 32'h50);
    tick(); tick();
    check("t5_empty",   {31'd0, sb_empty}, 32'd1);
    check("t5_nwrites", log_d.size(), 32'd2);

    // Reset discards pending stores.
    clear_log();
    ld_valid = 1'b1; ld_addr = 32'h80;
    push(32'h60, 32'h61); tick();
    push(32'h64, 32'h62); tick();
    push(32'h68, 32'h63); tick();
    st_valid = 1'b0; ld_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("t6_rst_we", {31'd0, dm_we}, 32'd0);
    tick();
    reset = 1'b0;
    #1;
    check("t6_empty",  {31'd0, sb_empty}, 32'd1);
    check("t6_ready",  {31'd0, st_ready}, 32'd1);
    check("t6_we",     {31'd0, dm_we}, 32'd0);
    tick(); tick();
    check("t6_nwrites", log_d.size(), 32'd0);
    check("t6_mem60",   mem[8'h18], 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
